uart_tx_frame_serializer: RTL

//  Parametrised UART transmit serializer; next generation of the TX shift stage.

---
 rtl/uart_tx_frame_serializer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit serializer: frames one word as start, DATA_W data bits, optional parity
// and 1 or 2 stop bits, with bit timing taken from an external baud_tick enable.
module uart_tx_frame_serializer #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned PARITY_EN     = 0,
  parameter int unsigned PARITY_ODD    = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned LSB_FIRST     = 1,
  parameter int unsigned TICKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              baud_tick,
  output logic              ready,
  output logic              busy,
  output logic              txd,
  output logic              frame_done
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_frame_serializer: DATA_W must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame_serializer: STOP_BITS must be 1 or 2");
  end
  if (TICKS_PER_BIT < 1 || TICKS_PER_BIT > 256) begin : g_bad_ticks
    $error("uart_tx_frame_serializer: TICKS_PER_BIT must be 1..256");
  end
  if (PARITY_EN > 1 || PARITY_ODD > 1 || LSB_FIRST > 1) begin : g_bad_flags
    $error("uart_tx_frame_serializer: PARITY_EN, PARITY_ODD and LSB_FIRST must be 0 or 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              parity_q, parity_d;
  logic [7:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              txd_q, txd_d;
  logic              frame_done_q, frame_done_d;
  logic              period_end;
  logic [DATA_W-1:0] shreg_next;
  logic              head_bit;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    parity_d     = parity_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    txd_d        = 1'b1;
    head_bit     = 1'b0;

    period_end = baud_tick && (tick_cnt_q == TICK_LAST);
    shreg_next = (LSB_FIRST != 0) ? {1'b0, shreg_q[DATA_W-1:1]}
                                  : {shreg_q[DATA_W-2:0], 1'b0};

    // A tick coincident with the accepting load is not counted: IDLE never advances tick_cnt.
    if (state_q != ST_IDLE && baud_tick) begin
      tick_cnt_d = period_end ? '0 : tick_cnt_q + 8'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d    = ST_START;
          shreg_d    = data_in;
          parity_d   = (PARITY_ODD != 0) ? ~^data_in : ^data_in;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      ST_START: begin
        if (period_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (period_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shreg_d   = shreg_next;
          end
        end
      end
      ST_PARITY: begin
        if (period_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (period_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // txd is registered from the next state so each bit appears with its state.
    head_bit = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[DATA_W-1];
    unique case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = head_bit;
      ST_PARITY: txd_d = parity_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      txd_q        <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      parity_q     <= parity_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      txd_q        <= txd_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign busy       = ~ready;
  assign txd        = txd_q;
  assign frame_done = frame_done_q;

endmodule
